// File: rtl/icache_refill_pkg.sv
// Instruction-cache state encoding, default geometry, derived field widths and address-field macros.
// Combinational helpers only; no latency, no flow control.
`ifndef ICACHE_REFILL_PKG_SV
`define ICACHE_REFILL_PKG_SV

`define IC_OFFSET(a, ow)      a[(ow)+1:2]
`define IC_INDEX(a, ow, iw)   a[(ow)+(iw)+1:(ow)+2]
`define IC_TAG(a, aw, ow, iw) a[(aw)-1:(ow)+(iw)+2]
`define IC_LINE(a, aw, ow)    a[(aw)-1:(ow)+2]

package icache_refill_pkg;

   localparam int IC_ADDR_W     = 32;
   localparam int IC_DATA_W     = 32;
   localparam int IC_LINES      = 64;
   localparam int IC_LINE_WORDS = 4;

   localparam int OFFSET_W = $clog2(IC_LINE_WORDS);
   localparam int INDEX_W  = $clog2(IC_LINES);
   localparam int TAG_W    = IC_ADDR_W - INDEX_W - OFFSET_W - 2;

   typedef enum logic [1:0] {
      IC_IDLE   = 2'd0,
      IC_REFILL = 2'd1,
      IC_FILL   = 2'd2
   } ic_state_e;

endpackage

`endif

// File: rtl/icache_line_ram.sv
// Valid/tag/data line store: async read, one synchronous write port, line invalidate and global valid clear.
// Read latency 0 cycles; writes land on the next rising edge; no backpressure.
module icache_line_ram #(
   parameter  int LINES      = 64,
   parameter  int LINE_WORDS = 4,
   parameter  int DATA_W     = 32,
   parameter  int TAG_W      = 24,
   localparam int IW         = $clog2(LINES),
   localparam int OW         = $clog2(LINE_WORDS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IW-1:0]     rd_idx_i,
   input  logic [OW-1:0]     rd_off_i,
   output logic              rd_vld_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [DATA_W-1:0] rd_dat_o,
   input  logic [IW-1:0]     wr_idx_i,
   input  logic [OW-1:0]     wr_off_i,
   input  logic              wr_word_en_i,
   input  logic [DATA_W-1:0] wr_dat_i,
   input  logic              wr_tag_en_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic              inv_line_i,
   input  logic              clr_all_i
);

   logic [LINES-1:0]  vld_q;
   logic [TAG_W-1:0]  tag_q [LINES];
   logic [DATA_W-1:0] dat_q [LINES][LINE_WORDS];

   // Global clear beats a tag write so a line filled alongside an invalidate ends up invalid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
      end else if (clr_all_i) begin
         vld_q <= '0;
      end else if (wr_tag_en_i) begin
         vld_q[wr_idx_i] <= 1'b1;
      end else if (inv_line_i) begin
         vld_q[wr_idx_i] <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_tag_en_i)  tag_q[wr_idx_i]           <= wr_tag_i;
      if (wr_word_en_i) dat_q[wr_idx_i][wr_off_i] <= wr_dat_i;
   end

   assign rd_vld_o = vld_q[rd_idx_i];
   assign rd_tag_o = tag_q[rd_idx_i];
   assign rd_dat_o = dat_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache_refill.sv
// Direct-mapped I-cache: 0-cycle hit, miss refills a whole line by word req/ack, stalling fetch via o_miss until filled.
// Memory side holds req/addr until ack; ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter int ADDR_W     = IC_ADDR_W,
   parameter int DATA_W     = IC_DATA_W,
   parameter int LINES      = IC_LINES,
   parameter int LINE_WORDS = IC_LINE_WORDS
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_inval,
   output logic [DATA_W-1:0] o_instr,
   output logic              o_miss,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
`ifdef ICACHE_STATS_EN
   output logic [31:0]       o_hit_cnt,
   output logic [31:0]       o_miss_cnt,
`endif
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_data
);

   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(LINES);
   localparam int TW = ADDR_W - IW - OW - 2;
   localparam int LW = ADDR_W - OW - 2;
   localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

   ic_state_e         state_q, state_d;
   logic [OW-1:0]     cnt_q, cnt_d;
   logic [LW-1:0]     base_q, base_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              pend_q, pend_d;

   logic [IW-1:0]     lk_idx;
   logic [OW-1:0]     lk_off;
   logic [TW-1:0]     lk_tag;
   logic              rd_vld;
   logic [TW-1:0]     rd_tag;
   logic [DATA_W-1:0] rd_dat;
   logic              hit;

   logic [IW-1:0]     wr_idx;
   logic              word_we, tag_we, inv_line, clr_all;
   logic              unused_addr_lsb;

   assign lk_idx          = `IC_INDEX(i_addr, OW, IW);
   assign lk_off          = `IC_OFFSET(i_addr, OW);
   assign lk_tag          = `IC_TAG(i_addr, ADDR_W, OW, IW);
   assign unused_addr_lsb = ^i_addr[1:0];

   icache_line_ram #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .DATA_W     (DATA_W),
      .TAG_W      (TW)
   ) u_ram (
      .clk_i        (Clk),
      .rst_i        (Rst),
      .rd_idx_i     (lk_idx),
      .rd_off_i     (lk_off),
      .rd_vld_o     (rd_vld),
      .rd_tag_o     (rd_tag),
      .rd_dat_o     (rd_dat),
      .wr_idx_i     (wr_idx),
      .wr_off_i     (cnt_q),
      .wr_word_en_i (word_we),
      .wr_dat_i     (i_mem_data),
      .wr_tag_en_i  (tag_we),
      .wr_tag_i     (base_q[LW-1:IW]),
      .inv_line_i   (inv_line),
      .clr_all_i    (clr_all)
   );

   assign hit     = i_req && rd_vld && (rd_tag == lk_tag);
   assign o_instr = hit ? rd_dat : '0;

   // In IDLE the only write is the invalidate of the line about to be refilled, addressed by fetch.
   assign wr_idx = (state_q == IC_IDLE) ? lk_idx : base_q[IW-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      req_d    = req_q;
      addr_d   = addr_q;
      pend_d   = pend_q;
      word_we  = 1'b0;
      tag_we   = 1'b0;
      inv_line = 1'b0;
      clr_all  = 1'b0;
      o_miss   = 1'b0;
      case (state_q)
         IC_IDLE: begin
            o_miss  = i_req && !hit;
            clr_all = i_inval;
            if (i_req && !hit) begin
               base_d   = `IC_LINE(i_addr, ADDR_W, OW);
               cnt_d    = '0;
               inv_line = 1'b1;
               req_d    = 1'b1;
               addr_d   = {`IC_LINE(i_addr, ADDR_W, OW), {OW{1'b0}}, 2'b00};
               pend_d   = 1'b0;
               state_d  = IC_REFILL;
            end
         end
         IC_REFILL: begin
            o_miss = 1'b1;
            pend_d = pend_q | i_inval;
            if (i_mem_ack) begin
               word_we = 1'b1;
               cnt_d   = cnt_q + OW'(1);
               if (cnt_q == LAST) begin
                  req_d   = 1'b0;
                  state_d = IC_FILL;
               end else begin
                  addr_d = {base_q, cnt_q + OW'(1), 2'b00};
               end
            end
         end
         IC_FILL: begin
            o_miss  = 1'b1;
            tag_we  = 1'b1;
            clr_all = pend_q | i_inval;
            pend_d  = 1'b0;
            state_d = IC_IDLE;
         end
         default: state_d = IC_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IC_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
      end
   end

   assign o_mem_req  = req_q;
   assign o_mem_addr = addr_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == IC_IDLE) begin
         if (hit && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (i_req && !hit && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign o_hit_cnt  = hit_cnt_q;
   assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: cold/conflict/slow-memory refills, redirect, invalidate, async reset.
// Memory model answers o_mem_req with word {16'hC0DE, addr[15:0]}.
module tb_icache_refill;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_inval;
   logic [31:0] o_instr;
   logic        o_miss;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ack = 1'b0;
   logic [31:0] i_mem_data = 32'h0;
`ifdef ICACHE_STATS_EN
   logic [31:0] o_hit_cnt;
   logic [31:0] o_miss_cnt;
   logic [31:0] mc0;
`endif

   int          n_chk = 0;
   int          n_err = 0;
   int          n;
   int          hold_viol = 0;
   int          wait_cnt = 0;
   bit          slow_mem = 1'b0;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [31:0] ack_log[$];

   always #5 Clk = ~Clk;

   icache_refill dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_inval    (i_inval),
      .o_instr    (o_instr),
      .o_miss     (o_miss),
      .o_mem_req  (o_mem_req),
      .o_mem_addr (o_mem_addr),
`ifdef ICACHE_STATS_EN
      .o_hit_cnt  (o_hit_cnt),
      .o_miss_cnt (o_miss_cnt),
`endif
      .i_mem_ack  (i_mem_ack),
      .i_mem_data (i_mem_data)
   );

   // Backing memory: optional ack only every 3rd requesting cycle; tracks request/address hold.
   always @(negedge Clk) begin
      if (o_mem_req && !Rst) begin
         if (prev_req && !prev_ack && o_mem_addr != prev_addr) hold_viol++;
         if (slow_mem && wait_cnt != 2) begin
            i_mem_ack = 1'b0;
            wait_cnt++;
         end else begin
            i_mem_ack  = 1'b1;
            i_mem_data = {16'hC0DE, o_mem_addr[15:0]};
            wait_cnt   = 0;
            ack_log.push_back(o_mem_addr);
         end
      end else begin
         if (prev_req && !prev_ack && !Rst) hold_viol++;
         i_mem_ack = 1'b0;
         wait_cnt  = 0;
      end
      prev_req  = o_mem_req;
      prev_ack  = i_mem_ack;
      prev_addr = o_mem_addr;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic req_at(input logic [31:0] a);
      @(negedge Clk);
      i_req  = 1'b1;
      i_addr = a;
      #1;
   endtask

   // Counts miss cycles from the current one until fetch sees a hit (bounded).
   task automatic wait_miss(output int cnt);
      cnt = 0;
      while (o_miss && cnt < 100) begin
         cnt++;
         @(negedge Clk);
         #1;
      end
   endtask

   initial begin
      Rst     = 1'b1;
      i_req   = 1'b0;
      i_addr  = 32'h0;
      i_inval = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      check("rst_miss",     {31'b0, o_miss},    32'h0);
      check("rst_mem_req",  {31'b0, o_mem_req}, 32'h0);
      check("rst_mem_addr", o_mem_addr,         32'h0);
      check("rst_instr",    o_instr,            32'h0);
      @(negedge Clk);
      Rst = 1'b0;

      // Cold miss at 0x100 with immediate acks.
      ack_log.delete();
      req_at(32'h100);
      check("cold_miss_now", {31'b0, o_miss}, 32'h1);
      wait_miss(n);
      check("cold_penalty", n, 32'd6);
      check("cold_nwords", ack_log.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         check("cold_addr", (ack_log.size() > i) ? ack_log[i] : 32'hxxxxxxxx, 32'h100 + 32'(4 * i));
      check("cold_instr", o_instr, 32'hC0DE0100);

      // Back-to-back hits on the filled line.
      for (int i = 1; i < 4; i++) begin
         req_at(32'h100 + 32'(4 * i));
         check("hit_miss", {31'b0, o_miss},    32'h0);
         check("hit_req",  {31'b0, o_mem_req}, 32'h0);
         check("hit_dat",  o_instr,            32'hC0DE0100 + 32'(4 * i));
      end

      // Conflict eviction: 0x500 shares index 16 with 0x100.
      req_at(32'h500);
      check("conf_miss", {31'b0, o_miss}, 32'h1);
      wait_miss(n);
      check("conf_penalty", n, 32'd6);
      check("conf_instr", o_instr, 32'hC0DE0500);
      req_at(32'h100);
      check("conf_remiss", {31'b0, o_miss}, 32'h1);
      wait_miss(n);
      check("conf_re_penalty", n, 32'd6);
      check("conf_re_instr", o_instr, 32'hC0DE0100);

      // Slow memory: 4 acks spaced 3 cycles apart -> 12 + 2 miss cycles.
      slow_mem  = 1'b1;
      hold_viol = 0;
      req_at(32'h30C);
      wait_miss(n);
      check("slow_penalty", n, 32'd14);
      check("slow_hold", hold_viol, 32'd0);
      check("slow_instr", o_instr, 32'hC0DE030C);
      slow_mem = 1'b0;

      // Invalidate in IDLE alongside a hit: data still returned this cycle.
      @(negedge Clk);
      i_req   = 1'b1;
      i_addr  = 32'h100;
      i_inval = 1'b1;
      #1;
      check("inv_hit_miss", {31'b0, o_miss}, 32'h0);
      check("inv_hit_dat",  o_instr,         32'hC0DE0100);
      @(negedge Clk);
      i_inval = 1'b0;
      #1;
      check("inv_after", {31'b0, o_miss}, 32'h1);

      // Redirect to 0x200 while 0x100 refills.
      ack_log.delete();
      @(negedge Clk);
      i_addr = 32'h200;
      #1;
      wait_miss(n);
      check("redir_penalty", n, 32'd11);
      check("redir_nwords", ack_log.size(), 32'd8);
      for (int i = 0; i < 8; i++)
         check("redir_addr", (ack_log.size() > i) ? ack_log[i] : 32'hxxxxxxxx,
               ((i < 4) ? 32'h100 : 32'h200) + 32'(4 * (i % 4)));
      check("redir_instr", o_instr, 32'hC0DE0200);
      req_at(32'h100);
      check("redir_old_hit", {31'b0, o_miss}, 32'h0);
      check("redir_old_dat", o_instr, 32'hC0DE0100);

      // Invalidate recorded during REFILL, applied when FILL completes.
`ifdef ICACHE_STATS_EN
      mc0 = o_miss_cnt;
`endif
      req_at(32'h600);
      check("rinv_miss", {31'b0, o_miss}, 32'h1);
      @(negedge Clk);
      i_inval = 1'b1;
      i_req   = 1'b0;
      #1;
      check("rinv_refill_miss", {31'b0, o_miss}, 32'h1);
      @(negedge Clk);
      i_inval = 1'b0;
      #1;
      wait_miss(n);
      check("rinv_rest", n, 32'd4);
      i_req  = 1'b1;
      i_addr = 32'h600;
      #1;
      check("rinv_fresh_gone", {31'b0, o_miss}, 32'h1);
      i_addr = 32'h200;
      #1;
      check("rinv_old_gone", {31'b0, o_miss}, 32'h1);
      i_req = 1'b0;
      req_at(32'h100);
      wait_miss(n);
      check("rinv_re_penalty", n, 32'd6);
      check("rinv_re_instr", o_instr, 32'hC0DE0100);
`ifdef ICACHE_STATS_EN
      check("stats_misses", o_miss_cnt - mc0, 32'd2);
`endif

      // Async reset in the middle of a refill.
      req_at(32'h700);
      @(negedge Clk);
      #1;
      check("mid_req", {31'b0, o_mem_req}, 32'h1);
      #2;
      Rst = 1'b1;
      #1;
      check("mid_rst_req", {31'b0, o_mem_req}, 32'h0);
      i_req = 1'b0;
      #1;
      check("mid_rst_miss", {31'b0, o_miss}, 32'h0);
      @(negedge Clk);
      Rst = 1'b0;
      req_at(32'h100);
      check("post_rst_miss", {31'b0, o_miss}, 32'h1);
      wait_miss(n);
      check("post_rst_penalty", n, 32'd6);
      check("post_rst_instr", o_instr, 32'hC0DE0100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Direct-mapped instruction cache with a line-refill state machine, sitting directly upstream of the fetch stage.
- Fetch presents a word address each cycle. The block returns the instruction on a hit, or raises the miss flag.
- On a miss it refills the whole line from the backing instruction memory through a req/ack word handshake.
- The miss flag drives the stall unit's I-cache-miss input, which stalls the PC and the IF/ID register.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, instruction/word width.
- LINES, 64, number of cache lines (power of two).
- LINE_WORDS, 4, words per line (power of two, >=2).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous active-high reset.
- i_req  in  1  fetch is requesting an instruction this cycle.
- i_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- i_inval  in  1  invalidate all lines (self-modifying code/boot).
- o_instr  out  DATA_W  instruction word; valid when i_req && !o_miss.
- o_miss  out  1  miss/refill in progress; fetch must hold i_addr stable.
- o_mem_req  out  1  word read request to backing memory.
- o_mem_addr  out  ADDR_W  word-aligned address of the requested word.
- i_mem_ack  in  1  backing memory returns i_mem_data this cycle.
- i_mem_data  in  DATA_W  returned word.

Behaviour:
- Address split: offset = [log2(LINE_WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- Storage per line: valid bit, tag, LINE_WORDS data words.
- Reset (async):
  - All valid bits cleared; state IDLE; refill word counter 0.
  - o_mem_req=0, o_mem_addr=0, o_miss=0, o_instr=0.
  - Data/tag contents are don't-care.
- Lookup is combinational from registered arrays. hit = i_req && valid[index] && tag match.
  - o_instr = data[index][offset] when hit, else 0.
  - o_miss = i_req && !hit in IDLE; o_miss = 1 in REFILL and FILL.
  - Hit latency is 0 cycles, so fetch sees the result the same cycle.
- State machine:
  - IDLE: on a miss, latch the line base (tag|index, offset 0), clear the counter, clear valid[index], go to REFILL.
  - REFILL:
    - o_mem_req=1 and o_mem_addr = line base + counter*4.
    - On i_mem_ack, write i_mem_data to data[index][counter] and increment the counter.
    - When the ack lands on counter == LINE_WORDS-1, go to FILL.
    - Without ack, hold the request and address; there is no timeout.
  - FILL: set valid[index], write the tag, deassert o_mem_req, return to IDLE. The next cycle the access hits, so miss penalty = LINE_WORDS ack cycles + 2.
- The refill fills from offset 0 in ascending order; there is no critical-word-first.
- o_mem_req is registered: it asserts the cycle after the miss is detected and drops the cycle after the final ack.
- i_inval:
  - In IDLE it clears all valid bits next edge; o_miss follows the post-clear state.
  - During REFILL/FILL it is recorded, and all valid bits are cleared when FILL completes (the fresh line is invalidated too).
- If i_req drops or i_addr changes during a refill (flush from the branch unit), the refill still completes for the latched line.
  - After FILL the new address is looked up normally.
  - Bus requests are never abandoned mid-line.
- Simultaneous hit and i_inval in IDLE: the hit data is returned this cycle; invalidation takes effect next edge.
- Rst asserted mid-refill: immediate return to IDLE with all lines invalid. The memory side must tolerate the dropped request.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, add outputs o_hit_cnt and o_miss_cnt, each 32 bits.
  - o_hit_cnt increments on each IDLE cycle with a hit.
  - o_miss_cnt increments on each IDLE→REFILL transition.
  - Both saturate at all-ones and reset to 0 on Rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/defines header alongside the pipeline defines holds:
  - state encoding constants (IC_IDLE, IC_REFILL, IC_FILL);
  - derived field-width localparams (OFFSET_W, INDEX_W, TAG_W);
  - field-extraction macros.
- One sub-module, icache_line_ram: a valid/tag/data array with an async-read port and a single write port (word write + tag/valid write + global valid clear).
- The FSM and counter stay in icache_refill.

Test Plan:
- Cold miss: reset, i_req=1, i_addr=0x100.
  - Required: o_miss=1 the same cycle, o_mem_addr sequence 0x100,0x104,0x108,0x10C with immediate acks.
  - Then o_miss=0 and o_instr = the word returned for 0x100.
- Hit after fill: read 0x104, 0x108, 0x10C back-to-back. Required: o_miss=0 every cycle and data match; no o_mem_req.
- Conflict eviction (LINES=64, 16-byte lines): access 0x100, then 0x500 (same index, new tag), then 0x100.
  - Required: 0x500 misses and refills; 0x100 misses again.
- Slow memory: ack only every 3rd cycle. Required: o_mem_req and o_mem_addr held stable between acks; penalty = 12+2 cycles for 4 words.
- Redirect mid-refill: change i_addr to 0x200 during the refill of 0x100.
  - Required: line 0x100 completes, then a 0x200 miss starts; a later 0x100 access hits.
- Invalidate: i_inval during REFILL. Required: after FILL all lines invalid and the next access to 0x100 misses. With ICACHE_STATS_EN, o_miss_cnt counts 2 misses.
